// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// alu_arb_pkg: shared types and constants for alu_share_arbiter.  Rev 1.0
// ============================================================================
package alu_arb_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arb_rr_picker.sv
`default_nettype none
// ============================================================================
// alu_arb_rr_picker: one-hot grant for two requesters; ptr picks the winner
// when both are valid, a lone valid requester always wins.  Rev 1.0
// ============================================================================
module alu_arb_rr_picker (
    input  logic [1:0] req_valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule : alu_arb_rr_picker
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter: two requesters share one registered ALU, one op in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties.  Rev 1.0
// ============================================================================
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]         alu_sel_q, alu_sel_d;
    logic               owner_q, owner_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [1:0]         grant;
    logic               pick_ptr;
    logic               accept;

    alu_arb_rr_picker u_picker (
        .req_valid (req_valid),
        .ptr       (pick_ptr),
        .grant     (grant)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick_ptr = 1'b0;
`else
    logic rr_ptr_q, rr_ptr_d;

    // Granting requester 0 points at 1 and vice versa, so grant[0] is the next pointer.
    assign rr_ptr_d = accept ? grant[0] : rr_ptr_q;
    assign pick_ptr = rr_ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        owner_d      = owner_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d   = grant[1] ? req1_a   : req0_a;
                    alu_b_d   = grant[1] ? req1_b   : req0_b;
                    alu_sel_d = grant[1] ? req1_sel : req0_sel;
                    owner_d   = grant[1];
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: begin
                // The ALU's registered outputs reflect this op's operands here.
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry;
                rsp_id_d     = owner_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 2'b00;
            owner_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            owner_q      <= owner_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != ST_IDLE);

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arbiter: vector table, directed corner sequences and a random
// run against a transaction-level model of alu_share_arbiter.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int W = 8;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_sel, req1_sel;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_sel;
    logic [W-1:0] alu_result = '0;
    logic         alu_zero = 1'b0, alu_carry = 1'b0;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, busy;
    logic [W-1:0] rsp_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .NREQ(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    // {carry, result}; SUB carry is the borrow, code 11 passes operand a.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] s);
        case (s)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {(a < b), a - b};
            OP_AND:  return {1'b0, a & b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [W:0] alu_t;
    always @(posedge clk) begin
        alu_t      = alu_ref(alu_a, alu_b, alu_sel);
        alu_result <= alu_t[W-1:0];
        alu_carry  <= alu_t[W];
        alu_zero   <= (alu_t[W-1:0] == '0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits (bounded) for a handshake, checks who got it, drops that valid after the edge.
    task automatic wait_accept(input string nm, input logic [1:0] exp_rdy);
        logic [1:0] got;
        int n = 0;
        #1;
        while (!(|(req_valid & req_ready)) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        got = req_ready;
        chk(nm, {30'd0, got}, {30'd0, exp_rdy});
        @(negedge clk);
        req_valid = req_valid & ~got;
        #1;
    endtask

    // Called one negedge after the accepting edge; response must appear two edges after accept.
    task automatic wait_resp(input string nm, input logic id, input logic [W-1:0] res,
                             input logic z, input logic c);
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_lat0"}, rsp_valid, 0);
        @(negedge clk); #1;
        chk({nm, "_lat1"}, rsp_valid, 0);
        @(negedge clk); #1;
        chk({nm, "_valid"}, rsp_valid, 1);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_res"}, rsp_result, res);
        chk({nm, "_zero"}, rsp_zero, z);
        chk({nm, "_carry"}, rsp_carry, c);
    endtask

    task automatic finish_resp(input string nm);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_rspclr"}, rsp_valid, 0);
    endtask

    typedef struct {
        logic [1:0]   v;
        logic [W-1:0] a0, b0;
        logic [1:0]   s0;
        logic [W-1:0] a1, b1;
        logic [1:0]   s1;
        logic         id;
        logic [W-1:0] res;
        logic         z, c;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int k);
        string nm;
        nm = $sformatf("vec%0d", k);
        @(negedge clk);
        req0_a = v.a0; req0_b = v.b0; req0_sel = v.s0;
        req1_a = v.a1; req1_b = v.b1; req1_sel = v.s1;
        req_valid = v.v;
        rsp_ready = 1'b1;
        wait_accept({nm, "_grant"}, v.id ? 2'b10 : 2'b01);
        chk({nm, "_alu_a"}, alu_a, v.id ? v.a1 : v.a0);
        chk({nm, "_alu_b"}, alu_b, v.id ? v.b1 : v.b0);
        chk({nm, "_alu_sel"}, alu_sel, v.id ? v.s1 : v.s0);
        wait_resp(nm, v.id, v.res, v.z, v.c);
        finish_resp(nm);
    endtask

    // Random-phase model state
    logic [W-1:0] ra[2], rb[2];
    logic [1:0]   rs[2];
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_s, exp_rdy, clr;
    logic         m_id;
    logic [W:0]   exp_t;
    bit           busy_m;
    int           age, last_g;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 8'd10,  8'd5,   OP_ADD, 8'd0,   8'd0,   OP_ADD, 1'b0, 8'd15,  1'b0, 1'b0};
        vecs[1] = '{2'b01, 8'd5,   8'd5,   OP_SUB, 8'd0,   8'd0,   OP_ADD, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[2] = '{2'b10, 8'd0,   8'd0,   OP_ADD, 8'd200, 8'd100, OP_ADD, 1'b1, 8'd44,  1'b0, 1'b1};
        vecs[3] = '{2'b10, 8'd0,   8'd0,   OP_ADD, 8'hF0,  8'h0F,  OP_AND, 1'b1, 8'd0,   1'b1, 1'b0};
        vecs[4] = '{2'b01, 8'd3,   8'd7,   OP_SUB, 8'd0,   8'd0,   OP_ADD, 1'b0, 8'd252, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 8'd0,   8'd0,   OP_ADD, 8'hAB,  8'h12,  2'b11,  1'b1, 8'hAB,  1'b0, 1'b0};
        vecs[6] = '{2'b01, 8'hFF,  8'h01,  OP_ADD, 8'd0,   8'd0,   OP_ADD, 1'b0, 8'd0,   1'b1, 1'b1};

        reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_sel = 2'b00;
        req1_a = '0; req1_b = '0; req1_sel = 2'b00;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_req_ready", {30'd0, req_ready}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Both valid straight out of reset: requester 0 first, then requester 1.
        @(negedge clk);
        req0_a = 8'd8; req0_b = 8'd1; req0_sel = OP_ADD;
        req1_a = 8'd4; req1_b = 8'd2; req1_sel = OP_AND;
        req_valid = 2'b11;
        wait_accept("both_first_grant", 2'b01);
        wait_resp("both_first", 1'b0, 8'd9, 1'b0, 1'b0);
        finish_resp("both_first");
        wait_accept("both_second_grant", 2'b10);
        wait_resp("both_second", 1'b1, 8'd0, 1'b1, 1'b0);
        finish_resp("both_second");

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Back-pressure in RESP.
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_a = 8'd20; req0_b = 8'd3; req0_sel = OP_SUB;
        req_valid = 2'b01;
        wait_accept("stall_grant", 2'b01);
        req1_a = 8'd7; req1_b = 8'd7; req1_sel = OP_AND;
        req_valid = 2'b10;
        wait_resp("stall", 1'b0, 8'd17, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_hold_valid", rsp_valid, 1);
            chk("stall_hold_res", rsp_result, 8'd17);
            chk("stall_hold_id", rsp_id, 0);
            chk("stall_ready", {30'd0, req_ready}, 0);
            chk("stall_busy", busy, 1);
        end
        finish_resp("stall");
        wait_accept("stall_next_grant", 2'b10);
        wait_resp("stall_next", 1'b1, 8'd7, 1'b0, 1'b0);
        finish_resp("stall_next");

        // Reset in EXEC discards the op and clears the pointer.
        @(negedge clk);
        req0_a = 8'd9; req0_b = 8'd9; req0_sel = OP_ADD;
        req_valid = 2'b01;
        wait_accept("rst_grant", 2'b01);
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst_no_rsp", rsp_valid, 0);
        end
        req0_a = 8'd1; req0_b = 8'd2; req0_sel = OP_ADD;
        req1_a = 8'd3; req1_b = 8'd4; req1_sel = OP_ADD;
        req_valid = 2'b11;
        wait_accept("rst_ptr_grant", 2'b01);
        wait_resp("rst_ptr", 1'b0, 8'd3, 1'b0, 1'b0);
        finish_resp("rst_ptr");
        wait_accept("rst_ptr2_grant", 2'b10);
        wait_resp("rst_ptr2", 1'b1, 8'd7, 1'b0, 1'b0);
        finish_resp("rst_ptr2");

        // Contention with both valid for three ops, then requester 0 drops out.
        pulse_reset();
        req0_a = 8'd1; req0_b = 8'd1; req0_sel = OP_ADD;
        req1_a = 8'd6; req1_b = 8'd3; req1_sel = OP_SUB;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] e;
            e = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
            wait_accept($sformatf("prio%0d_grant", i), e);
            req_valid = 2'b11;
            wait_resp($sformatf("prio%0d", i), e[1], e[1] ? 8'd3 : 8'd2, 1'b0, 1'b0);
            finish_resp($sformatf("prio%0d", i));
        end
        req_valid = 2'b10;
        wait_accept("prio_req1_grant", 2'b10);
        wait_resp("prio_req1", 1'b1, 8'd3, 1'b0, 1'b0);
        finish_resp("prio_req1");

        // Random traffic against the transaction-level model.
        pulse_reset();
        m_a = '0; m_b = '0; m_s = 2'b00; m_id = 1'b0;
        busy_m = 1'b0; age = 0; last_g = 1; clr = 2'b00;
        for (int r = 0; r < 2; r++) begin ra[r] = '0; rb[r] = '0; rs[r] = 2'b00; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req_valid = req_valid & ~clr;
            clr = 2'b00;
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    ra[r] = W'($urandom);
                    rb[r] = W'($urandom);
                    rs[r] = 2'($urandom);
                    req_valid[r] = 1'b1;
                end
            end
            req0_a = ra[0]; req0_b = rb[0]; req0_sel = rs[0];
            req1_a = ra[1]; req1_b = rb[1]; req1_sel = rs[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = 2'b00;
            if (!busy_m) begin
                if (req_valid == 2'b11) exp_rdy = (FIXED || last_g == 1) ? 2'b01 : 2'b10;
                else                    exp_rdy = req_valid;
            end
            chk("rnd_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
            chk("rnd_busy", busy, busy_m);
            chk("rnd_rsp_valid", rsp_valid, busy_m && age >= 2);
            chk("rnd_alu_a", alu_a, m_a);
            chk("rnd_alu_b", alu_b, m_b);
            chk("rnd_alu_sel", alu_sel, m_s);
            if (busy_m && age >= 2) begin
                exp_t = alu_ref(m_a, m_b, m_s);
                chk("rnd_rsp_id", rsp_id, m_id);
                chk("rnd_rsp_res", rsp_result, exp_t[W-1:0]);
                chk("rnd_rsp_zero", rsp_zero, exp_t[W-1:0] == '0);
                chk("rnd_rsp_carry", rsp_carry, exp_t[W]);
            end
            if (busy_m) begin
                if (age >= 2 && rsp_ready) busy_m = 1'b0;
                else                       age++;
            end else if (exp_rdy != 2'b00) begin
                m_id   = exp_rdy[1];
                m_a    = ra[m_id];
                m_b    = rb[m_id];
                m_s    = rs[m_id];
                busy_m = 1'b1;
                age    = 0;
                last_g = int'(m_id);
                clr    = exp_rdy;
            end
        end
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
